// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared types and constants for the serial pattern transmitter.
// Holds the FSM state encoding, the repetition-count width and the mapping
// that turns a requested count of 0 into an effective count of 1.
package serial_tx_pkg;

  localparam int REPS_W = 4;

  // A request for zero repetitions still sends the pattern once.
  localparam logic [REPS_W-1:0] REPS_ZERO_EFF = REPS_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  function automatic logic [REPS_W-1:0] eff_reps(input logic [REPS_W-1:0] r);
    return (r == '0) ? REPS_ZERO_EFF : r;
  endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// tx_shift_reg: WIDTH-bit loadable left-shift register, zero shifted in at the LSB.
// Ports: clk/rst_n (async active-low), load (parallel load of d, wins over shift),
//        shift (shift left by one), d (parallel data), msb (current bit 'WIDTH-1').
module tx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: captures a WIDTH-bit pattern on start and sends it MSB-first,
// one bit per clock, reps times back-to-back, then pulses done for one cycle.
// Ports: clk, rst_n (async active-low), start/data_in/reps (sampled when ready=1),
//        ready, bit_out, bit_valid, done (all decoded from registers only).
// Optional feature macro: SERIAL_PATTERN_TX_PARITY_EN appends one even-parity bit
// (XOR of the latched pattern) after every word.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [REPS_W-1:0] reps,
  output logic              ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  tx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [REPS_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [WIDTH-1:0]  pat_q, pat_d;

  logic             sr_load;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_din;
  logic             sr_msb;

  tx_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sr_load),
    .shift (sr_shift),
    .d     (sr_din),
    .msb   (sr_msb)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    pat_d     = pat_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_din    = pat_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_load   = 1'b1;
          sr_din    = data_in;
          pat_d     = data_in;
          rep_cnt_d = eff_reps(reps);
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        sr_shift = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          state_d = PAR;
`else
          // Word boundary: reload wins over shift so the next repetition's
          // MSB is on the line the very next cycle, with no gap.
          if (rep_cnt_q > REPS_W'(1)) begin
            sr_load   = 1'b1;
            rep_cnt_d = rep_cnt_q - 1'b1;
          end else begin
            rep_cnt_d = '0;
            state_d   = DONE;
          end
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
      PAR: begin
        if (rep_cnt_q > REPS_W'(1)) begin
          sr_load   = 1'b1;
          rep_cnt_d = rep_cnt_q - 1'b1;
          state_d   = SHIFT;
        end else begin
          rep_cnt_d = '0;
          state_d   = DONE;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      pat_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      pat_q     <= pat_d;
    end
  end

  // Outputs depend only on flops (state, shift-register MSB, latched pattern),
  // so nothing on the input side reaches them combinationally.
  always_comb begin
    ready     = 1'b0;
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE:    ready = 1'b1;
      SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = sr_msb;
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      PAR: begin
        bit_valid = 1'b1;
        bit_out   = ^pat_q;
      end
`endif
      DONE:    done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed bench for serial_pattern_tx at WIDTH=4.
// Inputs are driven on the falling edge and outputs sampled on the falling edge,
// so every sample sits half a cycle away from the active rising edge.
module tb_serial_pattern_tx;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data_in;
  logic [3:0]   reps;
  logic         ready;
  logic         bit_out;
  logic         bit_valid;
  logic         done;

  int n_chk  = 0;
  int n_pass = 0;

  serial_pattern_tx #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .reps      (reps),
    .ready     (ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one stream and checks it bit by bit. exp holds n bits MSB-first.
  // If inj >= 0, a conflicting start (pattern 1111, reps 7) is raised for one
  // rising edge while bit 'inj' is on the line; it must be ignored.
  task automatic send(input string tag, input logic [W-1:0] d, input logic [3:0] r,
                      input logic [31:0] exp, input int n, input int inj);
    int dones;
    dones = 0;
    @(negedge clk);
    check({tag, "_ready_pre"}, ready, 1'b1);
    start   = 1'b1;
    data_in = d;
    reps    = r;
    @(negedge clk);
    // Scramble the inputs after acceptance; they must have no effect.
    start   = 1'b0;
    data_in = ~d;
    reps    = 4'd9;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (done) dones++;
      check($sformatf("%s_valid%0d", tag, i), bit_valid, 1'b1);
      check($sformatf("%s_bit%0d", tag, i), bit_out, exp[n-1-i]);
      check($sformatf("%s_busy%0d", tag, i), ready, 1'b0);
      if (i == inj) begin
        start   = 1'b1;
        data_in = 4'hF;
        reps    = 4'h7;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (done) dones++;
    check({tag, "_done_valid"}, bit_valid, 1'b0);
    check({tag, "_done_bit"}, bit_out, 1'b0);
    check({tag, "_done_ready"}, ready, 1'b0);
    @(negedge clk);
    if (done) dones++;
    check({tag, "_idle_ready"}, ready, 1'b1);
    check({tag, "_idle_valid"}, bit_valid, 1'b0);
    check({tag, "_done_count"}, dones, 1);
  endtask

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam logic [31:0] E_1011_R1 = 32'b10111;
  localparam int          N_1011_R1 = 5;
  localparam logic [31:0] E_0110_R3 = 32'b011000110001100;
  localparam int          N_0110_R3 = 15;
  localparam logic [31:0] E_1011_R2 = 32'b1011110111;
  localparam int          N_1011_R2 = 10;
  localparam logic [31:0] E_1001_R1 = 32'b10010;
  localparam int          N_1001_R1 = 5;
`else
  localparam logic [31:0] E_1011_R1 = 32'b1011;
  localparam int          N_1011_R1 = 4;
  localparam logic [31:0] E_0110_R3 = 32'b011001100110;
  localparam int          N_0110_R3 = 12;
  localparam logic [31:0] E_1011_R2 = 32'b10111011;
  localparam int          N_1011_R2 = 8;
  localparam logic [31:0] E_1001_R1 = 32'b1001;
  localparam int          N_1001_R1 = 4;
`endif

  initial begin
    int dones;
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    reps    = '0;
    #2;
    check("rst_ready", ready, 1'b1);
    check("rst_valid", bit_valid, 1'b0);
    check("rst_bit", bit_out, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send("r1", 4'b1011, 4'd1, E_1011_R1, N_1011_R1, -1);
    send("r0", 4'b1011, 4'd0, E_1011_R1, N_1011_R1, -1);
    send("r3", 4'b0110, 4'd3, E_0110_R3, N_0110_R3, -1);
    send("ign", 4'b1011, 4'd2, E_1011_R2, N_1011_R2, 2);

    // Nothing may have been queued by the ignored start.
    @(negedge clk);
    check("ign_no_queue", bit_valid, 1'b0);

    // Reset in the middle of a word.
    dones = 0;
    start   = 1'b1;
    data_in = 4'b1011;
    reps    = 4'd1;
    @(negedge clk);
    start = 1'b0;
    check("mid_bit0", bit_out, 1'b1);
    @(negedge clk);
    check("mid_bit1", bit_out, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bit_valid, 1'b0);
    check("mid_rst_bit", bit_out, 1'b0);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_done", done, 1'b0);
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid_no_done", dones, 0);
    check("mid_idle_ready", ready, 1'b1);

    send("post", 4'b1001, 4'd1, E_1001_R1, N_1001_R1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-stream transmitter: captures a WIDTH-bit pattern on a start request and shifts it out MSB-first, one bit per clock, repeated a programmable number of times. It sits on the transmit side of the single-bit serial link consumed by the team's sequence-detector FSMs. It drives their one-bit `Input`, replacing hand-scheduled stimulus with a clocked, handshaked source.

## Interface
- `WIDTH`, default 8: pattern length in bits; legal range 2-32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  transmit request; accepted only on a rising edge where `ready`=1.
- `data_in`  in  WIDTH  pattern; sampled only on the accepting edge.
- `reps`  in  4  transmission count; sampled with `data_in`; 0 is treated as 1.
- `ready`  out  1  high in IDLE only.
- `bit_out`  out  1  serial data, registered; 0 whenever `bit_valid`=0.
- `bit_valid`  out  1  high on every cycle carrying a pattern or parity bit.
- `done`  out  1  one-cycle pulse after the final bit of the final repetition.

## Operation
- States: IDLE, SHIFT, PAR (exists only with the parity feature), DONE.
- IDLE: `ready`=1 and all other outputs 0. When `start`=1, latch `data_in` into the shift register, latch `reps` (0 becomes 1) into the repetition counter, clear the bit counter, and go to SHIFT.
- SHIFT: `bit_out` = shift-register MSB and `bit_valid`=1. Each cycle, shift left by one and increment the bit counter.
  - After bit WIDTH-1, with parity: go to PAR.
  - After bit WIDTH-1, without parity: if repetitions remain, reload the latched pattern, decrement the counter, and stay in SHIFT. Otherwise go to DONE.
- PAR: emit one parity bit with `bit_valid`=1, then apply the same repeat-or-DONE decision.
- DONE: `done`=1, `bit_valid`=0, `bit_out`=0, `ready`=0. Go to IDLE unconditionally on the next edge.
- Repetitions are back-to-back with no idle gap between them.
- `start` while not in IDLE is ignored, with no queuing.
- Changes on `data_in` or `reps` after acceptance have no effect.
- Reset values: state IDLE, `ready`=1, `bit_out`=0, `bit_valid`=0, `done`=0, and all counters 0.
- Reset asserted mid-transmission forces these values immediately. There is no partial-word completion, and no `done` pulse is produced.

## Timing
- Start accepted at edge k: the first bit is valid on the cycle after edge k, i.e. from edge k to edge k+1.
- Busy duration from acceptance to return to IDLE: reps_eff × (WIDTH + P) + 1 cycles, where P = 1 with parity and 0 without.
- The `done` cycle immediately follows the last valid bit. `ready` rises on the edge that ends the `done` cycle.
- Earliest next acceptance is the edge after `ready` rises. The minimum gap between streams is therefore one `done` cycle plus one IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SERIAL_PATTERN_TX_PARITY_EN`.
- Defined: after each WIDTH-bit word, one even-parity bit is sent (XOR of the latched pattern), with `bit_valid`=1. P = 1.
- Undefined: the PAR state and its logic are absent, and words are exactly WIDTH bits. P = 0.

## Structure
- Package `serial_tx_pkg` holds:
  - `tx_state_t`, the enum IDLE/SHIFT/PAR/DONE;
  - constant `REPS_W` = 4;
  - the constant mapping `reps` = 0 to an effective count of 1.
- One sub-module, `tx_shift_reg`: a WIDTH-bit loadable left-shift register with ports load, shift, d, and msb.
- The top level keeps the FSM, the bit counter ($clog2(WIDTH) bits), and the repetition counter.

## Test plan
All scenarios use WIDTH=4.
- `data_in`=4'b1011, `reps`=1, `start` high for one cycle → `bit_out` = 1,0,1,1 with `bit_valid`=1 for 4 cycles. Then `done`=1 for 1 cycle, then `ready`=1.
- `reps`=0, `data_in`=4'b1011 → output identical to the `reps`=1 case.
- `reps`=3, `data_in`=4'b0110 → 12 contiguous valid bits 011001100110, followed by exactly one `done` pulse.
- `start` re-asserted with `data_in`=4'b1111 during a transmission → ignored; the original stream is unchanged and there is one `done` pulse.
- `rst_n` driven low after 2 bits are sent → asynchronously `bit_valid`=0, `bit_out`=0, `ready`=1, and no `done` pulse. After release, a new start of 4'b1001 transmits correctly.
- With `SERIAL_PATTERN_TX_PARITY_EN`, `data_in`=4'b1011, `reps`=2 → 1,0,1,1,1,1,0,1,1,1, then `done`.
